// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache: FSM states, fixed line geometry
// and address field extraction helpers.
package dcache_pkg;

    // Word offset within a 256-bit line (8 x 32-bit words).
    localparam int unsigned OFFSET_W   = 3;
    // Byte offset bits below the index field (word offset + byte-in-word).
    localparam int unsigned LINE_OFF_W = 5;
    localparam int unsigned WORD_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        RETRY
    } state_e;

    // Tag field, right-aligned; caller narrows to its tag width.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned idx_w);
        return addr >> (LINE_OFF_W + idx_w);
    endfunction

    // Index field, right-aligned; caller narrows to its index width.
    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned idx_w);
        return (addr >> LINE_OFF_W) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Word offset within the line; byte bits [1:0] are ignored.
    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [31:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data storage for the direct-mapped cache.
// One combinational read port; one write port taking either a full line
// (refill: valid set, dirty cleared) or a single word (store hit: dirty set).
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned IDX_W     = 5,
    parameter int unsigned TAG_W     = 22,
    parameter int unsigned LINE_W    = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    // read port
    input  logic [IDX_W-1:0]    rd_idx,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [LINE_W-1:0]   rd_line,
    // write port
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic                we_line,
    input  logic [TAG_W-1:0]    line_tag,
    input  logic [LINE_W-1:0]   line_data,
    input  logic                we_word,
    input  logic [OFFSET_W-1:0] word_off,
    input  logic [WORD_W-1:0]   word_data
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_mem_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem_q [NUM_LINES];

    // Combinational read of the addressed line.
    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_dirty = dirty_q[rd_idx];
        rd_tag   = tag_mem_q[rd_idx];
        rd_line  = data_mem_q[rd_idx];
    end

    // Status bit update: refill makes a line valid+clean, a store makes it dirty.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (we_line) begin
            valid_d[wr_idx] = 1'b1;
            dirty_d[wr_idx] = 1'b0;
        end else if (we_word) begin
            dirty_d[wr_idx] = 1'b1;
        end
    end

    // Status bits are the only reset state in the cache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays: plain storage, not reset.
    always_ff @(posedge clk) begin
        if (we_line) begin
            tag_mem_q[wr_idx]  <= line_tag;
            data_mem_q[wr_idx] <= line_data;
        end else if (we_word) begin
            data_mem_q[wr_idx][{word_off, 5'b0} +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// L1 data cache controller: direct-mapped, write-back, write-allocate.
// Serves word loads/stores from the MEM stage; a miss stalls the pipeline,
// writes back a dirty victim, refills the line and then lets the request hit.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned LINE_W    = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - LINE_OFF_W - IDX_W;

    state_e state_q, state_d;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    req_tag;
    logic [OFFSET_W-1:0] off;
    logic                req;
    logic                hit;

    logic                rd_valid, rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_line;
    logic                we_line, we_word;

    assign idx     = IDX_W'(addr_index(p1_addr_i, IDX_W));
    assign req_tag = TAG_W'(addr_tag(p1_addr_i, IDX_W));
    assign off     = addr_offset(p1_addr_i);
    // Requests are masked while reset is held so every output reads 0.
    assign req     = rst_n & (p1_MemRead_i | p1_MemWrite_i);
    assign hit     = rd_valid && (rd_tag == req_tag);

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .LINE_W    (LINE_W)
    ) u_sram (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_idx    (idx),
        .we_line   (we_line),
        .line_tag  (req_tag),
        .line_data (mem_data_i),
        .we_word   (we_word),
        .word_off  (off),
        .word_data (p1_data_i)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, hit service, memory request and array write strobes.
    always_comb begin
        state_d      = state_q;
        p1_stall_o   = 1'b0;
        p1_data_o    = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        we_line      = 1'b0;
        we_word      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // Store wins when both requests are raised.
                        if (p1_MemWrite_i) begin
                            we_word = 1'b1;
                        end else begin
                            p1_data_o = rd_line[{off, 5'b0} +: 32];
                        end
                    end else begin
                        p1_stall_o = 1'b1;
                        state_d    = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_tag, idx, 5'b0};
                mem_data_o   = rd_line;
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, idx, 5'b0};
                if (mem_ack_i) begin
                    we_line = 1'b1;
                    state_d = RETRY;
                end
            end
            RETRY: begin
                p1_stall_o = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a hand-driven
// memory responder.
module tb_dcache_controller;

    logic         clk;
    logic         rst_n;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    int checks;
    int failures;
    int stall_cycles;

    dcache_controller #(
        .NUM_LINES (32),
        .LINE_W    (256),
        .ADDR_W    (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges at which the pipeline is stalled.
    initial stall_cycles = 0;
    always @(posedge clk) if (p1_stall_o === 1'b1) stall_cycles = stall_cycles + 1;

    // Absolute time limit so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [255:0] l, input int w);
        return l[w*32 +: 32];
    endfunction

    task automatic set_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        p1_addr_i     = a;
        p1_data_i     = d;
        #1;
    endtask

    // Wait for a memory request, check it, hold it for lat cycles, then ack.
    // Returns with the DUT in the state following the acked one.
    task automatic mem_serve(input string name, input logic exp_wr,
                             input logic [31:0] exp_addr, input int lat,
                             input logic [255:0] refill, output logic [255:0] wb_line);
        int n;
        n = 0;
        while (mem_enable_o !== 1'b1 && n < 40) begin
            tick(); #1;
            n++;
        end
        checks++;
        if (mem_enable_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_enable got=%b exp=1", name, mem_enable_o);
        end
        checks++;
        if (mem_write_o !== exp_wr) begin
            failures++;
            $display("FAIL %s_write got=%b exp=%b", name, mem_write_o, exp_wr);
        end
        checks++;
        if (mem_addr_o !== exp_addr) begin
            failures++;
            $display("FAIL %s_addr got=%h exp=%h", name, mem_addr_o, exp_addr);
        end
        checks++;
        if (p1_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_stall got=%b exp=1", name, p1_stall_o);
        end
        wb_line = mem_data_o;
        for (int k = 1; k < lat; k++) begin
            tick(); #1;
            checks++;
            if (mem_enable_o !== 1'b1 || mem_addr_o !== exp_addr ||
                mem_write_o !== exp_wr || mem_data_o !== wb_line) begin
                failures++;
                $display("FAIL %s_hold cycle=%0d got en=%b addr=%h exp en=1 addr=%h",
                         name, k, mem_enable_o, mem_addr_o, exp_addr);
            end
        end
        mem_data_i = refill;
        mem_ack_i  = 1'b1;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
    endtask

    // Checks the RETRY cycle then steps into IDLE.
    task automatic pass_retry(input string name);
        checks++;
        if (p1_stall_o !== 1'b1 || mem_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_retry got stall=%b en=%b exp stall=1 en=0",
                     name, p1_stall_o, mem_enable_o);
        end
        tick(); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        checks++;
        if (p1_stall_o !== 1'b0 || mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 ||
            mem_addr_o !== 32'h0 || p1_data_o !== 32'h0 || mem_data_o !== 256'h0) begin
            failures++;
            $display("FAIL reset_outputs got stall=%b en=%b wr=%b addr=%h data=%h exp all 0",
                     p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, p1_data_o);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); #1;
        checks++;
        if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0 || mem_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req got stall=%b data=%h en=%b exp 0/0/0",
                     p1_stall_o, p1_data_o, mem_enable_o);
        end
    endtask

    task automatic test_clean_miss();
        logic [255:0] dummy;
        int s0;
        set_req(1'b1, 1'b0, 32'h40, 32'h0);
        s0 = stall_cycles;
        checks++;
        if (p1_stall_o !== 1'b1 || mem_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL t1_miss_cycle got stall=%b en=%b exp stall=1 en=0",
                     p1_stall_o, mem_enable_o);
        end
        tick(); #1;
        mem_serve("t1_alloc", 1'b0, 32'h40, 10, make_line(32'h0), dummy);
        pass_retry("t1");
        checks++;
        if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0) begin
            failures++;
            $display("FAIL t1_hit got stall=%b data=%h exp stall=0 data=00000000",
                     p1_stall_o, p1_data_o);
        end
        checks++;
        if (stall_cycles - s0 !== 12) begin
            failures++;
            $display("FAIL t1_latency got=%0d exp=12", stall_cycles - s0);
        end
        set_req(1'b1, 1'b0, 32'h48, 32'h0);
        checks++;
        if (p1_data_o !== 32'h2 || p1_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL t1_word2 got=%h exp=00000002", p1_data_o);
        end
    endtask

    task automatic test_write_hit();
        set_req(1'b0, 1'b1, 32'h44, 32'hDEADBEEF);
        checks++;
        if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0) begin
            failures++;
            $display("FAIL t2_store got stall=%b data=%h exp 0/00000000", p1_stall_o, p1_data_o);
        end
        tick();
        set_req(1'b1, 1'b0, 32'h44, 32'h0);
        checks++;
        if (p1_data_o !== 32'hDEADBEEF || p1_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL t2_load got=%h exp=deadbeef", p1_data_o);
        end
    endtask

    task automatic test_dirty_evict();
        logic [255:0] wb;
        logic [255:0] dummy;
        set_req(1'b1, 1'b0, 32'h440, 32'h0);
        checks++;
        if (p1_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL t3_miss got stall=%b exp=1", p1_stall_o);
        end
        tick(); #1;
        mem_serve("t3_wb", 1'b1, 32'h40, 3, '0, wb);
        checks++;
        if (word_of(wb, 1) !== 32'hDEADBEEF || word_of(wb, 0) !== 32'h0 ||
            word_of(wb, 7) !== 32'h7) begin
            failures++;
            $display("FAIL t3_wb_data got w0=%h w1=%h w7=%h exp 00000000/deadbeef/00000007",
                     word_of(wb, 0), word_of(wb, 1), word_of(wb, 7));
        end
        mem_serve("t3_alloc", 1'b0, 32'h440, 2, make_line(32'h1000), dummy);
        pass_retry("t3");
        checks++;
        if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h1000) begin
            failures++;
            $display("FAIL t3_hit got stall=%b data=%h exp 0/00001000", p1_stall_o, p1_data_o);
        end
        set_req(1'b1, 1'b0, 32'h44C, 32'h0);
        checks++;
        if (p1_data_o !== 32'h1003) begin
            failures++;
            $display("FAIL t3_word3 got=%h exp=00001003", p1_data_o);
        end
    endtask

    task automatic test_store_miss();
        logic [255:0] wb;
        logic [255:0] dummy;
        set_req(1'b0, 1'b1, 32'h80, 32'hCAFEF00D);
        checks++;
        if (p1_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL t4_miss got stall=%b exp=1", p1_stall_o);
        end
        tick(); #1;
        mem_serve("t4_alloc", 1'b0, 32'h80, 4, make_line(32'h2000), dummy);
        pass_retry("t4");
        checks++;
        if (p1_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL t4_merge_stall got=%b exp=0", p1_stall_o);
        end
        tick();
        set_req(1'b1, 1'b0, 32'h80, 32'h0);
        checks++;
        if (p1_data_o !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL t4_merged got=%h exp=cafef00d", p1_data_o);
        end
        set_req(1'b1, 1'b0, 32'h480, 32'h0);
        tick(); #1;
        mem_serve("t4_wb", 1'b1, 32'h80, 2, '0, wb);
        checks++;
        if (word_of(wb, 0) !== 32'hCAFEF00D || word_of(wb, 1) !== 32'h2001) begin
            failures++;
            $display("FAIL t4_wb_data got w0=%h w1=%h exp cafef00d/00002001",
                     word_of(wb, 0), word_of(wb, 1));
        end
        mem_serve("t4_alloc2", 1'b0, 32'h480, 1, make_line(32'h3000), dummy);
        pass_retry("t4b");
        checks++;
        if (p1_data_o !== 32'h3000 || p1_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL t4_hit got=%h exp=00003000", p1_data_o);
        end
    endtask

    task automatic test_reset_abort();
        logic [255:0] dummy;
        set_req(1'b1, 1'b0, 32'hC0, 32'h0);
        tick(); #1;
        checks++;
        if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'hC0) begin
            failures++;
            $display("FAIL t5_alloc got en=%b addr=%h exp 1/000000c0", mem_enable_o, mem_addr_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_enable_o !== 1'b0 || p1_stall_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL t5_abort got en=%b stall=%b addr=%h exp 0/0/0",
                     mem_enable_o, p1_stall_o, mem_addr_o);
        end
        tick();
        rst_n = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        mem_data_i = make_line(32'hBAD0);
        mem_ack_i  = 1'b1;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        checks++;
        if (mem_enable_o !== 1'b0 || p1_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL t5_stale_ack got en=%b stall=%b exp 0/0", mem_enable_o, p1_stall_o);
        end
        set_req(1'b1, 1'b0, 32'hC0, 32'h0);
        checks++;
        if (p1_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL t5_remiss got stall=%b exp=1", p1_stall_o);
        end
        tick(); #1;
        mem_serve("t5_alloc", 1'b0, 32'hC0, 1, make_line(32'h4000), dummy);
        pass_retry("t5");
        checks++;
        if (p1_data_o !== 32'h4000) begin
            failures++;
            $display("FAIL t5_hit got=%h exp=00004000", p1_data_o);
        end
        // Line at index 2 was valid before reset; it must miss now.
        set_req(1'b1, 1'b0, 32'h440, 32'h0);
        checks++;
        if (p1_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL t5_valid_cleared got stall=%b exp=1", p1_stall_o);
        end
        tick(); #1;
        mem_serve("t5_alloc2", 1'b0, 32'h440, 1, make_line(32'h5000), dummy);
        pass_retry("t5b");
    endtask

    task automatic test_both_requests();
        logic [255:0] wb;
        logic [255:0] dummy;
        set_req(1'b1, 1'b1, 32'hC4, 32'h12345678);
        checks++;
        if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0) begin
            failures++;
            $display("FAIL t6_both got stall=%b data=%h exp 0/00000000", p1_stall_o, p1_data_o);
        end
        tick();
        set_req(1'b1, 1'b0, 32'hC4, 32'h0);
        checks++;
        if (p1_data_o !== 32'h12345678) begin
            failures++;
            $display("FAIL t6_stored got=%h exp=12345678", p1_data_o);
        end
        set_req(1'b1, 1'b0, 32'h4C0, 32'h0);
        tick(); #1;
        mem_serve("t6_wb", 1'b1, 32'hC0, 2, '0, wb);
        checks++;
        if (word_of(wb, 1) !== 32'h12345678 || word_of(wb, 0) !== 32'h4000) begin
            failures++;
            $display("FAIL t6_wb_data got w0=%h w1=%h exp 00004000/12345678",
                     word_of(wb, 0), word_of(wb, 1));
        end
        mem_serve("t6_alloc", 1'b0, 32'h4C0, 1, make_line(32'h6000), dummy);
        pass_retry("t6");
        checks++;
        if (p1_data_o !== 32'h6000 || p1_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL t6_hit got=%h exp=00006000", p1_data_o);
        end
        set_req(1'b0, 1'b0, 32'h4C0, 32'h0);
        checks++;
        if (p1_data_o !== 32'h0 || p1_stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL t6_no_req got data=%h stall=%b en=%b exp 0/0/0",
                     p1_data_o, p1_stall_o, mem_enable_o);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_dirty_evict();
        test_store_miss();
        test_reset_abort();
        test_both_requests();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
